// File: rtl/core_lsu_if.sv
// Request/response and data-bus signals between EXEC, the load/store unit and the core data bus.
// slave is the LSU's view; master is the view of the surrounding core and bus.
interface core_lsu_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        busy;
  logic        done;
  logic        misaligned;
  logic [31:0] mem_rdata;

  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  bus_ready, bus_rdata,
    output busy, done, misaligned, mem_rdata,
    output bus_valid, bus_write, bus_addr, bus_wstrb, bus_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output bus_ready, bus_rdata,
    input  busy, done, misaligned, mem_rdata,
    input  bus_valid, bus_write, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/core_lsu.sv
// MEM-stage load/store unit: one request at a time, one valid/ready bus transfer per access,
// alignment errors trapped before the bus.
module core_lsu (
  input  logic       clk,
  input  logic       rst_n,
  core_lsu_if.slave  lsu
);

  typedef enum logic [1:0] {StIdle, StBus, StDone, StErr} state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_rdata;

  logic        w_req_bad;
  logic        w_accept;
  logic        w_load_fire;
  logic [1:0]  w_off;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  // Alignment is judged on the live request so the error path costs no extra cycle.
  always_comb begin
    w_req_bad = 1'b1;
    unique case (lsu.req_size)
      2'd0:    w_req_bad = 1'b0;
      2'd1:    w_req_bad = lsu.req_addr[0];
      2'd2:    w_req_bad = |lsu.req_addr[1:0];
      default: w_req_bad = 1'b1;
    endcase
  end

  assign w_accept    = (r_state == StIdle) && lsu.req_valid;
  assign w_load_fire = (r_state == StBus) && lsu.bus_ready && !r_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (lsu.req_valid) begin
          w_state_next = w_req_bad ? StErr : StBus;
        end
      end
      StBus: begin
        if (lsu.bus_ready) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      StErr:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    lsu.busy       = 1'b0;
    lsu.done       = 1'b0;
    lsu.misaligned = 1'b0;
    lsu.bus_valid  = 1'b0;
    unique case (r_state)
      StIdle: ;
      StBus: begin
        lsu.busy      = 1'b1;
        lsu.bus_valid = 1'b1;
      end
      StDone: begin
        lsu.busy = 1'b1;
        lsu.done = 1'b1;
      end
      StErr: begin
        lsu.busy       = 1'b1;
        lsu.done       = 1'b1;
        lsu.misaligned = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_off = r_addr[1:0];

  // Shifting the addressed lane down to bit 0 keeps byte and half extraction uniform.
  always_comb begin
    w_shifted   = lsu.bus_rdata >> {w_off, 3'b000};
    w_load_data = lsu.bus_rdata;
    unique case (r_size)
      2'd0:    w_load_data = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_load_data = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = lsu.bus_rdata;
    endcase
  end

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = r_wdata;
    if (r_write) begin
      unique case (r_size)
        2'd0: begin
          w_wstrb = 4'b0001 << w_off;
          w_wdata = {4{r_wdata[7:0]}};
        end
        2'd1: begin
          w_wstrb = 4'b0011 << w_off;
          w_wdata = {2{r_wdata[15:0]}};
        end
        2'd2:    w_wstrb = 4'b1111;
        default: w_wstrb = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_write    <= lsu.req_write;
        r_size     <= lsu.req_size;
        r_unsigned <= lsu.req_unsigned;
        r_addr     <= lsu.req_addr;
        r_wdata    <= lsu.req_wdata;
      end
      if (w_load_fire) begin
        r_mem_rdata <= w_load_data;
      end
    end
  end

  // Bus fields come straight from the latched request, so they hold steady through wait states.
  assign lsu.bus_write = r_write;
  assign lsu.bus_addr  = {r_addr[31:2], 2'b00};
  assign lsu.bus_wstrb = w_wstrb;
  assign lsu.bus_wdata = w_wdata;
  assign lsu.mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: scoreboard of expected completions plus per-scenario bus checks.
module tb_core_lsu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core_lsu_if lsu_if ();

  core_lsu u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lsu   (lsu_if)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          xfer_cnt = 0;
  int          valid_rises = 0;
  logic [31:0] last_rdata = 32'd0;

  always @(posedge clk) begin
    if (lsu_if.bus_valid && lsu_if.bus_ready) xfer_cnt <= xfer_cnt + 1;
  end

  always @(posedge lsu_if.bus_valid) valid_rises <= valid_rises + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1);
  end

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                           input logic [1:0] off, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = (off == 2'd2) ? d[31:16] : d[15:0];
    case (sz)
      2'd0:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return d;
    endcase
  endfunction

  // Presents a request for exactly one rising edge; returns at the negedge of cycle 1.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    lsu_if.req_valid    = 1'b1;
    lsu_if.req_write    = wr;
    lsu_if.req_size     = sz;
    lsu_if.req_unsigned = uns;
    lsu_if.req_addr     = addr;
    lsu_if.req_wdata    = wd;
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, output int lat, output bit to);
    lat = start;
    to  = 1'b0;
    while (lsu_if.done !== 1'b1) begin
      if (lat >= 40) begin
        to = 1'b1;
        return;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (lsu_if.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", lsu_if.busy); else n_pass++;
    n_total++; if (lsu_if.done !== 1'b0) $display("FAIL reset done: got %b want 0", lsu_if.done); else n_pass++;
    n_total++; if (lsu_if.misaligned !== 1'b0) $display("FAIL reset misaligned: got %b want 0", lsu_if.misaligned); else n_pass++;
    n_total++; if (lsu_if.mem_rdata !== 32'd0) $display("FAIL reset mem_rdata: got %h want 0", lsu_if.mem_rdata); else n_pass++;
    n_total++;
    if ({lsu_if.bus_valid, lsu_if.bus_write, lsu_if.bus_addr, lsu_if.bus_wstrb, lsu_if.bus_wdata} !== 70'd0)
      $display("FAIL reset bus outputs: got v=%b w=%b a=%h s=%b d=%h want all 0", lsu_if.bus_valid,
               lsu_if.bus_write, lsu_if.bus_addr, lsu_if.bus_wstrb, lsu_if.bus_wdata);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_byte_load();
    exp_t e; int lat; bit to;
    lsu_if.bus_ready = 1'b1;
    lsu_if.bus_rdata = 32'h80FF_0000;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b0, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080, 2});
      issue(1'b0, 2'd0, 1'(k), 32'h1003, 32'h0);
      n_total++; if (lsu_if.bus_valid !== 1'b1) $display("FAIL byte_load bus_valid: got %b want 1", lsu_if.bus_valid); else n_pass++;
      n_total++; if (lsu_if.bus_addr !== 32'h1000) $display("FAIL byte_load bus_addr: got %h want 00001000", lsu_if.bus_addr); else n_pass++;
      n_total++; if (lsu_if.bus_wstrb !== 4'b0000) $display("FAIL byte_load wstrb: got %b want 0000", lsu_if.bus_wstrb); else n_pass++;
      wait_done(1, lat, to);
      e = sb.pop_front();
      n_total++; if (to || lat != e.lat) $display("FAIL byte_load latency: got %0d want %0d", lat, e.lat); else n_pass++;
      n_total++; if (lsu_if.mem_rdata !== e.rdata) $display("FAIL byte_load mem_rdata: got %h want %h", lsu_if.mem_rdata, e.rdata); else n_pass++;
      n_total++; if (lsu_if.misaligned !== e.err) $display("FAIL byte_load misaligned: got %b want %b", lsu_if.misaligned, e.err); else n_pass++;
      last_rdata = e.rdata;
    end
  endtask

  task automatic test_load_lanes();
    exp_t e; int lat; bit to; logic [31:0] d;
    lsu_if.bus_ready = 1'b1;
    for (int off = 0; off < 4; off++) begin
      for (int sz = 0; sz < 3; sz++) begin
        for (int uns = 0; uns < 2; uns++) begin
          if ((sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0)) continue;
          d = $urandom();
          if (sz == 0 && uns == 0) d = d | 32'h8080_8080;
          lsu_if.bus_rdata = d;
          sb.push_back('{1'b0, ref_load(2'(sz), 1'(uns), 2'(off), d), 2});
          issue(1'b0, 2'(sz), 1'(uns), 32'h8000 + 32'(off), 32'h0);
          wait_done(1, lat, to);
          e = sb.pop_front();
          n_total++;
          if (to || lat != e.lat || lsu_if.mem_rdata !== e.rdata)
            $display("FAIL load_lanes off=%0d sz=%0d uns=%0d: got %h lat %0d want %h lat %0d",
                     off, sz, uns, lsu_if.mem_rdata, lat, e.rdata, e.lat);
          else n_pass++;
          last_rdata = e.rdata;
        end
      end
    end
  endtask

  task automatic test_stores();
    exp_t e; int lat; bit to; logic [31:0] wd;
    lsu_if.bus_ready = 1'b1;
    lsu_if.bus_rdata = 32'hFFFF_FFFF;
    sb.push_back('{1'b0, last_rdata, 2});
    issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_ABCD);
    n_total++; if (lsu_if.bus_write !== 1'b1) $display("FAIL half_store bus_write: got %b want 1", lsu_if.bus_write); else n_pass++;
    n_total++; if (lsu_if.bus_addr !== 32'h2000) $display("FAIL half_store bus_addr: got %h want 00002000", lsu_if.bus_addr); else n_pass++;
    n_total++; if (lsu_if.bus_wstrb !== 4'b1100) $display("FAIL half_store wstrb: got %b want 1100", lsu_if.bus_wstrb); else n_pass++;
    n_total++; if (lsu_if.bus_wdata !== 32'hABCD_ABCD) $display("FAIL half_store wdata: got %h want abcdabcd", lsu_if.bus_wdata); else n_pass++;
    wait_done(1, lat, to);
    e = sb.pop_front();
    n_total++; if (to || lat != e.lat) $display("FAIL half_store latency: got %0d want %0d", lat, e.lat); else n_pass++;
    n_total++; if (lsu_if.mem_rdata !== e.rdata) $display("FAIL half_store mem_rdata: got %h want %h", lsu_if.mem_rdata, e.rdata); else n_pass++;

    for (int off = 0; off < 5; off++) begin
      wd = $urandom();
      sb.push_back('{1'b0, last_rdata, 2});
      if (off < 4) issue(1'b1, 2'd0, 1'b0, 32'h2010 + 32'(off), wd);
      else issue(1'b1, 2'd2, 1'b0, 32'h2018, wd);
      n_total++;
      if (off < 4 && (lsu_if.bus_wstrb !== 4'(1 << off) || lsu_if.bus_wdata !== {4{wd[7:0]}}))
        $display("FAIL byte_store off=%0d: got strb %b data %h want strb %b data %h", off,
                 lsu_if.bus_wstrb, lsu_if.bus_wdata, 4'(1 << off), {4{wd[7:0]}});
      else if (off == 4 && (lsu_if.bus_wstrb !== 4'b1111 || lsu_if.bus_wdata !== wd))
        $display("FAIL word_store: got strb %b data %h want strb 1111 data %h",
                 lsu_if.bus_wstrb, lsu_if.bus_wdata, wd);
      else n_pass++;
      wait_done(1, lat, to);
      e = sb.pop_front();
      n_total++;
      if (to || lat != e.lat || lsu_if.mem_rdata !== e.rdata)
        $display("FAIL store_complete off=%0d: got %h lat %0d want %h lat %0d", off,
                 lsu_if.mem_rdata, lat, e.rdata, e.lat);
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    exp_t e; int lat; bit to;
    lsu_if.bus_ready = 1'b0;
    lsu_if.bus_rdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b0, 32'hDEAD_BEEF, 5});
    issue(1'b0, 2'd2, 1'b1, 32'h4000, 32'h0);
    lat = 1;
    repeat (3) begin
      n_total++;
      if ({lsu_if.bus_valid, lsu_if.bus_write, lsu_if.bus_addr} !== {1'b1, 1'b0, 32'h4000})
        $display("FAIL wait_states stable cycle %0d: got v=%b w=%b a=%h want v=1 w=0 a=00004000",
                 lat, lsu_if.bus_valid, lsu_if.bus_write, lsu_if.bus_addr);
      else n_pass++;
      @(negedge clk);
      lat++;
    end
    lsu_if.bus_ready = 1'b1;
    wait_done(lat, lat, to);
    e = sb.pop_front();
    n_total++; if (to || lat != e.lat) $display("FAIL wait_states latency: got %0d want %0d", lat, e.lat); else n_pass++;
    n_total++; if (lsu_if.mem_rdata !== e.rdata) $display("FAIL wait_states mem_rdata: got %h want %h", lsu_if.mem_rdata, e.rdata); else n_pass++;
    last_rdata = e.rdata;
  endtask

  task automatic test_misaligned();
    exp_t e; int lat; bit to; int rises0;
    logic [31:0] addrs[3];
    logic [1:0]  sizes[3];
    addrs = '{32'h3001, 32'h3003, 32'h3000};
    sizes = '{2'd2, 2'd1, 2'd3};
    lsu_if.bus_ready = 1'b1;
    lsu_if.bus_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      rises0 = valid_rises;
      sb.push_back('{1'b1, last_rdata, 1});
      issue(1'(i == 1), sizes[i], 1'b0, addrs[i], 32'hCAFE_F00D);
      wait_done(1, lat, to);
      e = sb.pop_front();
      n_total++; if (to || lat != e.lat) $display("FAIL misaligned[%0d] latency: got %0d want %0d", i, lat, e.lat); else n_pass++;
      n_total++; if (lsu_if.misaligned !== e.err) $display("FAIL misaligned[%0d] flag: got %b want %b", i, lsu_if.misaligned, e.err); else n_pass++;
      n_total++; if (lsu_if.mem_rdata !== e.rdata) $display("FAIL misaligned[%0d] mem_rdata: got %h want %h", i, lsu_if.mem_rdata, e.rdata); else n_pass++;
      @(negedge clk);
      n_total++; if (valid_rises != rises0) $display("FAIL misaligned[%0d] bus_valid rose: got %0d rises want 0", i, valid_rises - rises0); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; bit to; int x0;
    x0 = xfer_cnt;
    lsu_if.bus_ready = 1'b0;
    lsu_if.bus_rdata = 32'h0000_AB00;
    sb.push_back('{1'b0, 32'h0000_AB00, 3});
    issue(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0);
    lsu_if.req_valid = 1'b1;
    lsu_if.req_write = 1'b1;
    lsu_if.req_size  = 2'd2;
    lsu_if.req_addr  = 32'h6000;
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    n_total++;
    if (lsu_if.bus_addr !== 32'h5000 || lsu_if.bus_write !== 1'b0)
      $display("FAIL busy_ignore: got a=%h w=%b want a=00005000 w=0", lsu_if.bus_addr, lsu_if.bus_write);
    else n_pass++;
    lsu_if.bus_ready = 1'b1;
    wait_done(2, lat, to);
    e = sb.pop_front();
    n_total++;
    if (to || lat != e.lat || lsu_if.mem_rdata !== e.rdata)
      $display("FAIL busy_first: got %h lat %0d want %h lat %0d", lsu_if.mem_rdata, lat, e.rdata, e.lat);
    else n_pass++;
    // Held from the done cycle; must be taken in the following (idle) cycle.
    lsu_if.req_valid    = 1'b1;
    lsu_if.req_write    = 1'b0;
    lsu_if.req_size     = 2'd0;
    lsu_if.req_unsigned = 1'b1;
    lsu_if.req_addr     = 32'h6001;
    sb.push_back('{1'b0, 32'h0000_00AB, 2});
    @(negedge clk);
    n_total++; if (lsu_if.busy !== 1'b0) $display("FAIL b2b idle after done: got busy=%b want 0", lsu_if.busy); else n_pass++;
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    n_total++;
    if (lsu_if.bus_valid !== 1'b1 || lsu_if.bus_addr !== 32'h6000)
      $display("FAIL b2b accept: got v=%b a=%h want v=1 a=00006000", lsu_if.bus_valid, lsu_if.bus_addr);
    else n_pass++;
    wait_done(1, lat, to);
    e = sb.pop_front();
    n_total++;
    if (to || lat != e.lat || lsu_if.mem_rdata !== e.rdata)
      $display("FAIL b2b second: got %h lat %0d want %h lat %0d", lsu_if.mem_rdata, lat, e.rdata, e.lat);
    else n_pass++;
    last_rdata = e.rdata;
    @(negedge clk);
    n_total++; if (xfer_cnt - x0 != 2) $display("FAIL b2b transfer count: got %0d want 2", xfer_cnt - x0); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    exp_t e; int lat; bit to; bit done_seen;
    lsu_if.bus_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0);
    n_total++; if (lsu_if.bus_valid !== 1'b1) $display("FAIL rst_mid in BUS: got bus_valid=%b want 1", lsu_if.bus_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (lsu_if.bus_valid !== 1'b0 || lsu_if.busy !== 1'b0)
      $display("FAIL rst_mid async: got v=%b busy=%b want 0 0", lsu_if.bus_valid, lsu_if.busy);
    else n_pass++;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (lsu_if.done !== 1'b0) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (lsu_if.done !== 1'b0) done_seen = 1'b1;
    n_total++; if (done_seen) $display("FAIL rst_mid abandoned: got done=1 want no done"); else n_pass++;
    last_rdata = 32'd0;
    lsu_if.bus_ready = 1'b1;
    lsu_if.bus_rdata = 32'h1234_5678;
    sb.push_back('{1'b0, 32'h1234_5678, 2});
    issue(1'b0, 2'd2, 1'b0, 32'h7004, 32'h0);
    wait_done(1, lat, to);
    e = sb.pop_front();
    n_total++;
    if (to || lat != e.lat || lsu_if.mem_rdata !== e.rdata)
      $display("FAIL rst_mid recovery: got %h lat %0d want %h lat %0d", lsu_if.mem_rdata, lat, e.rdata, e.lat);
    else n_pass++;
  endtask

  initial begin
    lsu_if.req_valid    = 1'b0;
    lsu_if.req_write    = 1'b0;
    lsu_if.req_size     = 2'd0;
    lsu_if.req_unsigned = 1'b0;
    lsu_if.req_addr     = 32'd0;
    lsu_if.req_wdata    = 32'd0;
    lsu_if.bus_ready    = 1'b0;
    lsu_if.bus_rdata    = 32'd0;
    test_reset();
    test_byte_load();
    test_load_lanes();
    test_stores();
    test_wait_states();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
